// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: exception codes, exc flag bit positions,
// register numbers, sequencer state encoding and small helpers.
package cp0_pkg;

    // Cause.ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Bit positions inside the per-lane exc flag vector
    localparam int FLG_ADEL_IF = 0;
    localparam int FLG_RI      = 1;
    localparam int FLG_OV      = 2;
    localparam int FLG_BP      = 3;
    localparam int FLG_SYS     = 4;
    localparam int FLG_ADEL_D  = 5;
    localparam int FLG_ERET    = 6;
    localparam int FLG_ADES    = 7;

    // CP0 register numbers
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TRAP     = 3'd1,
        ST_FLUSH    = 3'd2,
        ST_REDIRECT = 3'd3,
        ST_WR2      = 3'd4
    } trap_state_e;

    // Where BadVAddr comes from for a given exception
    typedef enum logic [1:0] {
        BADV_NONE  = 2'd0,
        BADV_PC    = 2'd1,
        BADV_VADDR = 2'd2
    } badv_src_e;

    // Delay-slot instructions restart at the branch in front of them
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/cp0_exc_prio.sv
// Per-lane exception encoder: turns the raw exc flag vector into the
// single highest-priority ExcCode, an ERET indication and the BadVAddr source.
module cp0_exc_prio
    import cp0_pkg::*;
(
    input  logic [7:0] exc,
    output logic       is_exc,
    output logic       is_eret,
    output logic [4:0] code,
    output badv_src_e  badv_src
);

    // Fixed priority chain; ERET only counts when no real exception is flagged
    always_comb begin
        is_exc   = 1'b1;
        is_eret  = 1'b0;
        code     = 5'd0;
        badv_src = BADV_NONE;
        if (exc[FLG_ADEL_IF]) begin
            code     = EXC_ADEL;
            badv_src = BADV_PC;
        end else if (exc[FLG_RI]) begin
            code = EXC_RI;
        end else if (exc[FLG_OV]) begin
            code = EXC_OV;
        end else if (exc[FLG_BP]) begin
            code = EXC_BP;
        end else if (exc[FLG_SYS]) begin
            code = EXC_SYS;
        end else if (exc[FLG_ADEL_D]) begin
            code     = EXC_ADEL;
            badv_src = BADV_VADDR;
        end else if (exc[FLG_ADES]) begin
            code     = EXC_ADES;
            badv_src = BADV_VADDR;
        end else if (exc[FLG_ERET]) begin
            is_exc  = 1'b0;
            is_eret = 1'b1;
        end else begin
            is_exc = 1'b0;
        end
    end

endmodule

// File: rtl/cp0_trap_sequencer.sv
// Trap sequencer for the dual-issue MEM stage. Picks the oldest trap
// (interrupt/exception/ERET) across both lanes, writes the trap record into
// CP0, flushes the pipe, then redirects fetch. Also splits same-cycle MTC0
// writes from both lanes into two CP0 write cycles.
module cp0_trap_sequencer
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_1,
    input  logic        valid_2,
    input  logic [7:0]  exc_1,
    input  logic [7:0]  exc_2,
    input  logic [31:0] pc_1,
    input  logic [31:0] pc_2,
    input  logic        bd_1,
    input  logic        bd_2,
    input  logic [31:0] vaddr_1,
    input  logic [31:0] vaddr_2,
    input  logic        mtc0_1,
    input  logic        mtc0_2,
    input  logic [4:0]  mtc0_addr_1,
    input  logic [4:0]  mtc0_addr_2,
    input  logic [31:0] mtc0_data_1,
    input  logic [31:0] mtc0_data_2,
    input  logic        int_pending,
    input  logic        exl,
    input  logic [31:0] epc_i,
    input  logic        redirect_ready,
    output logic        trap_we,
    output logic [4:0]  trap_code,
    output logic [31:0] trap_epc,
    output logic        trap_bd,
    output logic        badv_we,
    output logic [31:0] badv,
    output logic        exl_clr,
    output logic        cp0_we,
    output logic [4:0]  cp0_waddr,
    output logic [31:0] cp0_wdata,
    output logic        flush_1,
    output logic        flush_2,
    output logic        stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    // Remaining FLUSH-state cycles minus one. The TRAP cycle already flushes,
    // so a trap spends one FLUSH cycle fewer than an ERET or an ignored trap.
    localparam logic [7:0] FLUSH_LAST_DIRECT = 8'(FLUSH_CYCLES - 32'd1);
    localparam logic [7:0] FLUSH_LAST_TRAP   = 8'(FLUSH_CYCLES - 32'd2);

    trap_state_e state_r, state_nxt_s;

    logic        is_exc1_s, is_eret1_s, is_exc2_s, is_eret2_s;
    logic [4:0]  code1_s, code2_s;
    badv_src_e   badv1_s, badv2_s;

    logic        int1_s, trap1_s, trap2_raw_s, trap2_s, take_trap_s;
    logic        sel_eret_s, sel_bd_s;
    logic [4:0]  sel_code_s;
    badv_src_e   sel_badv_s;
    logic [31:0] sel_pc_s, sel_vaddr_s;
    logic        m1_s, m2_s;
    logic        load_rec_s, load_wr2_s;
    logic [7:0]  cnt_nxt_s;

    logic [7:0]  cnt_r;
    logic [4:0]  code_r;
    logic [31:0] epc_r;
    logic        bd_r;
    logic        badv_en_r;
    logic [31:0] badv_r;
    logic [31:0] redir_pc_r;
    logic        lane2_only_r;
    logic [4:0]  wr2_addr_r;
    logic [31:0] wr2_data_r;

    cp0_exc_prio u_prio_1 (
        .exc      (exc_1),
        .is_exc   (is_exc1_s),
        .is_eret  (is_eret1_s),
        .code     (code1_s),
        .badv_src (badv1_s)
    );

    cp0_exc_prio u_prio_2 (
        .exc      (exc_2),
        .is_exc   (is_exc2_s),
        .is_eret  (is_eret2_s),
        .code     (code2_s),
        .badv_src (badv2_s)
    );

    // Interrupts attach to lane 1 and beat its exceptions; lane 2 only when lane 1 is clean
    assign int1_s      = int_pending && !exl && valid_1;
    assign trap1_s     = int1_s || (valid_1 && (is_exc1_s || is_eret1_s));
    assign trap2_raw_s = valid_2 && (is_exc2_s || is_eret2_s);
    assign trap2_s     = !trap1_s && trap2_raw_s;
    assign take_trap_s = trap1_s || trap2_s;

    // MTC0 is dropped on a trapping lane and on lane 2 when lane 1 kills it
    assign m1_s = valid_1 && mtc0_1 && !trap1_s;
    assign m2_s = valid_2 && mtc0_2 && !trap1_s && !trap2_raw_s;

    // Select the fields of the winning trap
    always_comb begin
        sel_eret_s  = 1'b0;
        sel_code_s  = 5'd0;
        sel_badv_s  = BADV_NONE;
        sel_pc_s    = pc_2;
        sel_bd_s    = bd_2;
        sel_vaddr_s = vaddr_2;
        if (trap1_s) begin
            sel_eret_s  = !int1_s && is_eret1_s;
            sel_code_s  = int1_s ? EXC_INT : code1_s;
            sel_badv_s  = int1_s ? BADV_NONE : badv1_s;
            sel_pc_s    = pc_1;
            sel_bd_s    = bd_1;
            sel_vaddr_s = vaddr_1;
        end else begin
            sel_eret_s = is_eret2_s;
            sel_code_s = code2_s;
            sel_badv_s = badv2_s;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        load_rec_s     = 1'b0;
        load_wr2_s     = 1'b0;
        trap_we        = 1'b0;
        trap_code      = 5'd0;
        trap_epc       = 32'd0;
        trap_bd        = 1'b0;
        badv_we        = 1'b0;
        badv           = 32'd0;
        exl_clr        = 1'b0;
        cp0_we         = 1'b0;
        cp0_waddr      = 5'd0;
        cp0_wdata      = 32'd0;
        flush_1        = 1'b0;
        flush_2        = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        if (!reset) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (m1_s && m2_s) begin
                        cp0_we = 1'b1;
                        if (mtc0_addr_1 == mtc0_addr_2) begin
                            cp0_waddr = mtc0_addr_2;
                            cp0_wdata = mtc0_data_2;
                        end else begin
                            cp0_waddr   = mtc0_addr_1;
                            cp0_wdata   = mtc0_data_1;
                            stall       = 1'b1;
                            load_wr2_s  = 1'b1;
                            state_nxt_s = ST_WR2;
                        end
                    end else if (m1_s) begin
                        cp0_we    = 1'b1;
                        cp0_waddr = mtc0_addr_1;
                        cp0_wdata = mtc0_data_1;
                    end else if (m2_s) begin
                        cp0_we    = 1'b1;
                        cp0_waddr = mtc0_addr_2;
                        cp0_wdata = mtc0_data_2;
                    end else begin
                        cp0_we = 1'b0;
                    end
                    if (take_trap_s) begin
                        stall      = 1'b1;
                        load_rec_s = 1'b1;
                        if (sel_eret_s) begin
                            exl_clr     = 1'b1;
                            cnt_nxt_s   = FLUSH_LAST_DIRECT;
                            state_nxt_s = ST_FLUSH;
                        end else if (exl) begin
                            // Nested exception: flush and re-vector without a record
                            cnt_nxt_s   = FLUSH_LAST_DIRECT;
                            state_nxt_s = ST_FLUSH;
                        end else begin
                            state_nxt_s = ST_TRAP;
                        end
                    end else begin
                        load_rec_s = 1'b0;
                    end
                end
                ST_TRAP: begin
                    trap_we   = 1'b1;
                    trap_code = code_r;
                    trap_epc  = epc_r;
                    trap_bd   = bd_r;
                    badv_we   = badv_en_r;
                    badv      = badv_r;
                    flush_1   = !lane2_only_r;
                    flush_2   = 1'b1;
                    stall     = 1'b1;
                    if (FLUSH_CYCLES == 32'd1) begin
                        state_nxt_s = ST_REDIRECT;
                    end else begin
                        cnt_nxt_s   = FLUSH_LAST_TRAP;
                        state_nxt_s = ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    flush_1 = !lane2_only_r;
                    flush_2 = 1'b1;
                    stall   = 1'b1;
                    if (cnt_r == 8'd0) begin
                        state_nxt_s = ST_REDIRECT;
                    end else begin
                        cnt_nxt_s = cnt_r - 8'd1;
                    end
                end
                ST_REDIRECT: begin
                    redirect_valid = 1'b1;
                    redirect_pc    = redir_pc_r;
                    stall          = 1'b1;
                    if (redirect_ready) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_REDIRECT;
                    end
                end
                ST_WR2: begin
                    cp0_we      = 1'b1;
                    cp0_waddr   = wr2_addr_r;
                    cp0_wdata   = wr2_data_r;
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, flush counter, latched trap record and deferred lane 2 write
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 8'd0;
            code_r       <= 5'd0;
            epc_r        <= 32'd0;
            bd_r         <= 1'b0;
            badv_en_r    <= 1'b0;
            badv_r       <= 32'd0;
            redir_pc_r   <= 32'd0;
            lane2_only_r <= 1'b0;
            wr2_addr_r   <= 5'd0;
            wr2_data_r   <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (load_rec_s) begin
                code_r       <= sel_code_s;
                epc_r        <= epc_of(sel_pc_s, sel_bd_s);
                bd_r         <= sel_bd_s;
                badv_en_r    <= (sel_badv_s != BADV_NONE);
                badv_r       <= (sel_badv_s == BADV_PC)    ? sel_pc_s :
                                (sel_badv_s == BADV_VADDR) ? sel_vaddr_s : 32'd0;
                redir_pc_r   <= sel_eret_s ? epc_i : EXC_VECTOR;
                lane2_only_r <= !trap1_s;
            end
            if (load_wr2_s) begin
                wr2_addr_r <= mtc0_addr_2;
                wr2_data_r <= mtc0_data_2;
            end
        end
    end

endmodule
